// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline: datapath width,
// memory-stage state encoding and the default memory timeout.
package cpu_pkg;

   localparam int DATA_W          = 16;
   localparam int TIMEOUT_DEFAULT = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HALTED = 2'd2
   } mas_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Small counter with clear/enable/expire. SAT=0: down-counter reloaded with
// LIMIT on clear, expiring at zero. SAT=1: up-counter that sticks at all-ones.
module mem_timeout_ctr #(
   parameter int W     = 8,
   parameter int LIMIT = 0,
   parameter bit SAT   = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         expire
);

   assign expire = SAT ? (&cnt) : (cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= SAT ? '0 : W'(LIMIT);
      else if (en && !expire)
         cnt <= SAT ? cnt + 1'b1 : cnt - 1'b1;
   end

endmodule

// File: rtl/mem_access_stage.sv
// Data-memory access stage: issues loads/stores over a req/done handshake,
// stalls the pipeline while an access is outstanding, flags misalignment/timeout.
module mem_access_stage #(
   parameter int DATA_W  = cpu_pkg::DATA_W,
   parameter int TIMEOUT = cpu_pkg::TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_halt,
   input  logic [DATA_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] read_data,
   output logic              stall,
   output logic              err,
   output logic              halted,
   output logic [DATA_W-1:0] stall_cnt
);
   import cpu_pkg::*;

   // The timer reloads with TIMEOUT-2 so the abort lands on the TIMEOUT-th
   // cycle of the access, counting the issue cycle.
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   mas_state_e        state_q, state_d;
   logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
   logic              wr_q, err_q, halted_q;
   logic              access, misal;
   logic              issue, err_set, halt_set, ld_rdata;
   logic              tmr_clr, tmr_en, tmr_exp;
   logic [TW-1:0]     tmr_cnt;
   logic              scnt_sat;
   logic              unused_ok;

   assign access    = ex_valid & (ex_mem_read | ex_mem_write) & ~halted_q;
   assign misal     = ex_addr[0];
   assign err       = err_q;
   assign halted    = halted_q;
   assign unused_ok = ^{tmr_cnt, scnt_sat};

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      read_data = rdata_q;
      stall     = 1'b0;
      issue     = 1'b0;
      err_set   = 1'b0;
      halt_set  = 1'b0;
      ld_rdata  = 1'b0;
      tmr_clr   = 1'b0;
      tmr_en    = 1'b0;
      // While reset is held every output stays at its reset value even if
      // the upstream registers still present a memory op.
      if (rst) begin
         case (state_q)
            ST_IDLE: begin
               if (access && !misal) begin
                  mem_req   = 1'b1;
                  mem_wr    = ex_mem_write;
                  mem_addr  = ex_addr;
                  mem_wdata = ex_wdata;
                  issue     = 1'b1;
                  if (mem_done) begin
                     if (!ex_mem_write) begin
                        read_data = mem_rdata;
                        ld_rdata  = 1'b1;
                     end
                  end else begin
                     stall   = 1'b1;
                     tmr_clr = 1'b1;
                     state_d = ST_WAIT;
                  end
               end else if (access) begin
                  read_data = '0;
                  err_set   = 1'b1;
               end else if (ex_valid && ex_halt) begin
                  halt_set = 1'b1;
                  state_d  = ST_HALTED;
               end
            end
            ST_WAIT: begin
               mem_req = 1'b1;
               mem_wr  = wr_q;
               if (mem_done) begin
                  if (!wr_q) begin
                     read_data = mem_rdata;
                     ld_rdata  = 1'b1;
                  end
                  state_d = ST_IDLE;
               end else if (tmr_exp) begin
                  read_data = '0;
                  err_set   = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  stall  = 1'b1;
                  tmr_en = 1'b1;
               end
            end
            ST_HALTED: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (issue) begin
            addr_q  <= ex_addr;
            wdata_q <= ex_wdata;
            wr_q    <= ex_mem_write;
         end
         if (ld_rdata) rdata_q  <= mem_rdata;
         if (err_set)  err_q    <= 1'b1;
         if (halt_set) halted_q <= 1'b1;
      end
   end

   mem_timeout_ctr #(.W(TW), .LIMIT(TIMEOUT-2), .SAT(1'b0)) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .cnt    (tmr_cnt),
      .expire (tmr_exp)
   );

   mem_timeout_ctr #(.W(DATA_W), .LIMIT(0), .SAT(1'b1)) u_stall_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (1'b0),
      .en     (stall),
      .cnt    (stall_cnt),
      .expire (scnt_sat)
   );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random loads/stores
// against a word-array memory model with per-access latency.
module tb_mem_access_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_halt = 1'b0;
   logic [15:0] ex_addr = '0, ex_wdata = '0;
   logic        mem_req, mem_wr, mem_done = 1'b0;
   logic [15:0] mem_addr, mem_wdata, mem_rdata = '0, read_data, stall_cnt;
   logic        stall, err, halted;

   int          vectors = 0, miscompares = 0;
   logic [15:0] memm [256];
   logic [15:0] exp_rdata = '0, exp_scnt = '0;
   logic        exp_err = 1'b0, exp_halted = 1'b0;

   always #5 clk = ~clk;

   mem_access_stage #(.DATA_W(16), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_halt(ex_halt), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .read_data(read_data), .stall(stall), .err(err), .halted(halted),
      .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_status();
      chk("err", {15'd0, err}, {15'd0, exp_err});
      chk("halted", {15'd0, halted}, {15'd0, exp_halted});
      chk("stall_cnt", stall_cnt, exp_scnt);
   endtask

   // One memory instruction held in EX/MEM until it retires; the memory
   // answers on cycle 'lat' of the access (0 = never). Stops after max_cyc.
   task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                         input int lat, input int max_cyc);
      bit          done, abort;
      logic [15:0] rv;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge clk);
         ex_valid = 1'b1; ex_mem_read = !wr; ex_mem_write = wr; ex_halt = 1'b0;
         ex_addr = a; ex_wdata = wd;
         done = (lat == cyc);
         rv = (done && !wr) ? memm[a[7:0]] : 16'($urandom);
         mem_done = done; mem_rdata = rv;
         #1;
         chk_status();
         if (exp_halted) begin
            chk("halted_req", {15'd0, mem_req}, 16'd0);
            chk("halted_stall", {15'd0, stall}, 16'd0);
            chk("halted_rdata", read_data, exp_rdata);
            return;
         end
         if (a[0]) begin
            chk("misal_req", {15'd0, mem_req}, 16'd0);
            chk("misal_stall", {15'd0, stall}, 16'd0);
            chk("misal_rdata", read_data, 16'd0);
            exp_err = 1'b1;
            return;
         end
         abort = !done && (cyc == TO);
         chk("req", {15'd0, mem_req}, 16'd1);
         chk("wr", {15'd0, mem_wr}, {15'd0, wr});
         chk("addr", mem_addr, a);
         chk("wdata", mem_wdata, wd);
         chk("stall", {15'd0, stall}, {15'd0, !done && !abort});
         chk("read_data", read_data, (done && !wr) ? rv : (abort ? 16'd0 : exp_rdata));
         if (!done && !abort && exp_scnt != 16'hFFFF) exp_scnt++;
         if (done) begin
            if (wr) memm[a[7:0]] = wd;
            else    exp_rdata = rv;
            return;
         end
         if (abort) begin
            exp_err = 1'b1;
            return;
         end
      end
   endtask

   task automatic idle(input int n, input bit late_done);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_halt = 1'b0;
         mem_done = late_done; mem_rdata = 16'($urandom);
         #1;
         chk_status();
         chk("idle_req", {15'd0, mem_req}, 16'd0);
         chk("idle_stall", {15'd0, stall}, 16'd0);
         chk("idle_rdata", read_data, exp_rdata);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, {15'd0, mem_req}, 16'd0);
      chk({tag, "_wr"}, {15'd0, mem_wr}, 16'd0);
      chk({tag, "_addr"}, mem_addr, 16'd0);
      chk({tag, "_wdata"}, mem_wdata, 16'd0);
      chk({tag, "_rdata"}, read_data, 16'd0);
      chk({tag, "_stall"}, {15'd0, stall}, 16'd0);
      chk({tag, "_err"}, {15'd0, err}, 16'd0);
      chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
      chk({tag, "_scnt"}, stall_cnt, 16'd0);
   endtask

   initial begin
      logic [15:0] a;
      for (int i = 0; i < 256; i++) memm[i] = 16'($urandom);

      // reset
      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // zero-latency hit
      memm[8'h10] = 16'hBEEF;
      access(1'b0, 16'h0010, 16'h0000, 1, 10);
      chk("hit_data", exp_rdata, 16'hBEEF);
      idle(1, 1'b0);

      // 3-cycle load
      memm[8'h00] = 16'h1234;
      access(1'b0, 16'h0200, 16'h0000, 3, 10);
      idle(1, 1'b0);
      chk("load3_scnt", stall_cnt, 16'd2);

      // store then load, back-to-back
      access(1'b1, 16'h0004, 16'hA5A5, 2, 10);
      access(1'b0, 16'h0004, 16'h0000, 2, 10);
      idle(1, 1'b0);
      chk("st_ld_data", read_data, 16'hA5A5);

      // misaligned load
      access(1'b0, 16'h0003, 16'h0000, 1, 10);
      idle(2, 1'b0);

      // timeout, then a late mem_done is ignored
      access(1'b0, 16'h0100, 16'h0000, 0, 10);
      idle(1, 1'b1);
      idle(1, 1'b0);

      // random traffic
      for (int n = 0; n < 40; n++) begin
         a = {8'h00, 8'($urandom)};
         a[0] = ($urandom_range(0, 7) == 0);
         access(1'($urandom), a, 16'($urandom), $urandom_range(1, 5), 10);
         if ($urandom_range(0, 2) == 0) idle(1, 1'($urandom));
      end

      // reset mid-WAIT: outputs drop immediately
      access(1'b0, 16'h0040, 16'h0000, 0, 2);
      #2 rst = 1'b0;
      #1;
      chk_all_zero("midwait_rst");
      exp_rdata = '0; exp_err = 1'b0; exp_halted = 1'b0; exp_scnt = '0;
      @(negedge clk);
      ex_valid = 1'b0; mem_done = 1'b0;
      rst = 1'b1;
      idle(1, 1'b0);

      // HALT, then further accesses are ignored
      @(negedge clk);
      ex_valid = 1'b1; ex_halt = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      mem_done = 1'b0;
      #1;
      chk_status();
      chk("halt_req", {15'd0, mem_req}, 16'd0);
      chk("halt_stall", {15'd0, stall}, 16'd0);
      exp_halted = 1'b1;
      access(1'b0, 16'h0020, 16'h0000, 1, 10);
      access(1'b1, 16'h0022, 16'h5555, 2, 10);
      idle(2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Data-memory access stage of the 16-bit five-stage pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues loads and stores to a multi-cycle data memory through a req/done handshake, stalls the pipeline while an access is outstanding, and presents load data to MEM/WB.
- Flags misaligned accesses and memory timeouts.

Parameters:
- DATA_W, 16, data and address width.
- TIMEOUT, 64, maximum WAIT cycles before an access is aborted with an error; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_halt  in  1  instruction is HALT.
- ex_addr  in  DATA_W  effective address (ALU result).
- ex_wdata  in  DATA_W  store data.
- mem_req  out  1  access request to data memory.
- mem_wr  out  1  1 = write, 0 = read; valid only while mem_req=1.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_done  in  1  memory completes the current access this cycle.
- mem_rdata  in  DATA_W  read data; valid only when mem_done=1.
- read_data  out  DATA_W  load data to MEM/WB.
- stall  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers; MEM/WB captures a bubble.
- err  out  1  sticky: misaligned access or timeout occurred.
- halted  out  1  sticky: HALT has passed this stage.
- stall_cnt  out  DATA_W  saturating count of stall cycles.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req=0; mem_wr=0; mem_addr=0; mem_wdata=0; read_data=0; stall=0; err=0; halted=0; stall_cnt=0; timeout counter=0. Reset asserted mid-access abandons the access; no completion is reported.
- access = ex_valid & (ex_mem_read | ex_mem_write) & ~halted.
- Misaligned means ex_addr[0]=1.
- States:
  - IDLE
  - WAIT (request outstanding)
  - HALTED
- IDLE, access and aligned:
  - mem_req=1 combinationally, driven from the ex_* inputs; mem_wr=ex_mem_write.
  - Address and data are latched into holding registers at the clock edge.
  - mem_done=1 in the same cycle: zero-latency hit. stall=0, read_data=mem_rdata combinationally, stay in IDLE.
  - Otherwise: stall=1, next state WAIT, timeout counter cleared.
- IDLE, access and misaligned:
  - No request is issued; err set next edge; stall=0; read_data=0.
  - The instruction retires; the write is suppressed.
- IDLE, ex_valid & ex_halt: halted set next edge; next state HALTED.
  - A HALT with a memory op is not a legal encoding; behaviour is undefined.
- WAIT:
  - mem_req=1; mem_wr/mem_addr/mem_wdata driven from the holding registers, stable for the whole wait.
  - stall=1 unless mem_done=1.
  - mem_done=1: read_data=mem_rdata combinationally and latched into rdata_q; stall=0 that cycle so MEM/WB captures the result; next state IDLE.
  - mem_done=0: timeout counter increments. When it reaches TIMEOUT-1: err set, next state IDLE, stall=0 in that cycle, read_data=0. A mem_done arriving after the abort is ignored.
- HALTED: mem_req=0, stall=0; all further accesses are ignored until reset.
- read_data outside a completion cycle holds rdata_q; a store completion leaves rdata_q unchanged.
- stall_cnt increments each cycle stall=1 and saturates at all-ones.
- ex_* inputs are ignored while in WAIT. The upstream registers are frozen by stall, so the inputs are stable anyway.
- Back-to-back accesses: completion in cycle N with a new access presented in cycle N+1 issues in N+1 with no bubble.

Decomposition:
- Shared package (cpu_pkg): DATA_W, the state encoding (IDLE=2'd0, WAIT=2'd1, HALTED=2'd2), and TIMEOUT default.
- One sub-module: mem_timeout_ctr. Parameterized down-counter with clear/enable/expire; also instanced for stall_cnt with saturate mode.

Test Plan:
1. Zero-latency hit: load at 0x0010 with mem_done=1 the same cycle, mem_rdata=0xBEEF -> stall never asserted; read_data=0xBEEF that cycle; stall_cnt=0.
2. 3-cycle load: load at 0x0200, mem_done on the 3rd cycle with 0x1234 -> stall=1 for 2 cycles; mem_addr stays 0x0200 throughout; read_data=0x1234; stall_cnt=2.
3. Store then load back-to-back: store 0xA5A5 to 0x0004 (2-cycle), then load 0x0004 -> requests issued without an idle cycle; mem_wr=1 then 0; read_data for the store cycle is unchanged from the prior value.
4. Misaligned: load at 0x0003 -> mem_req stays 0; err=1 next cycle and remains 1; no stall.
5. Timeout with TIMEOUT=4: load, mem_done held 0 -> stall=1 for 3 cycles; abort on the 4th (stall=0, err=1); a later mem_done is ignored.
6. Reset mid-WAIT, then HALT: rst=0 during WAIT -> all outputs zero immediately. Then HALT followed by a load -> halted=1 and mem_req never asserts.
